// File: rtl/wb_pkg.sv
//------------------------------------------------------------------------------
// Module      : wb_pkg
// Description : Shared types and constants for the writeback buffer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package wb_pkg;

    localparam int WB_DEFAULT_DEPTH = 4;
    localparam int WB_ADDR_W        = 5;
    localparam int WB_DATA_W        = 32;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage : wb_pkg

`default_nettype wire

// File: rtl/wb_fwd_match.sv
//------------------------------------------------------------------------------
// Module      : wb_fwd_match
// Description : Youngest-match search over the pending writeback entries.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_fwd_match
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEFAULT_DEPTH
) (
    input  wb_entry_t                       entries_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]        rd_ptr_i,
    input  logic [$clog2(DEPTH+1)-1:0]      count_i,
    input  logic [WB_ADDR_W-1:0]            addr_i,
    output logic                            hit_o,
    output logic [WB_DATA_W-1:0]            data_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0] w_idx;

    // Walk oldest to youngest so the last match found is the youngest one.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = rd_ptr_i + PW'(k);
            if ((CW'(k) < count_i) && (addr_i != '0) &&
                (entries_i[w_idx].addr == addr_i)) begin
                hit_o  = 1'b1;
                data_o = entries_i[w_idx].data;
            end
        end
    end

endmodule : wb_fwd_match

`default_nettype wire

// File: rtl/wb_buffer.sv
//------------------------------------------------------------------------------
// Module      : wb_buffer
// Description : In-order writeback FIFO in front of a register file write port,
//               with optional read-port forwarding (macro WB_BUFFER_FWD_EN).
//               N and R must match the wb_entry_t field widths in wb_pkg.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_buffer
    import wb_pkg::*;
#(
    parameter int N     = WB_DATA_W,
    parameter int R     = WB_ADDR_W,
    parameter int DEPTH = WB_DEFAULT_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [R-1:0]                 in_addr,
    input  logic [N-1:0]                 in_data,
    output logic                         wr_en,
    output logic [R-1:0]                 wr_addr,
    output logic [N-1:0]                 wr_data,
    input  logic                         wr_ready,
    input  logic [R-1:0]                 fwd_addr1,
    input  logic [R-1:0]                 fwd_addr2,
    output logic                         fwd_hit1,
    output logic                         fwd_hit2,
    output logic [N-1:0]                 fwd_data1,
    output logic [N-1:0]                 fwd_data2,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    wb_entry_t     mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic      w_enq;
    logic      w_deq;
    wb_entry_t w_head;

    assign in_ready = (count_q != FULL_COUNT);
    assign wr_en    = (count_q != '0);

    // Register 0 is hardwired zero: the handshake completes but nothing is stored.
    assign w_enq    = in_valid && in_ready && (in_addr != '0);
    assign w_deq    = wr_en && wr_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (w_enq) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_deq) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (w_enq && !w_deq) begin
            count_d = count_q + 1'b1;
        end else if (!w_enq && w_deq) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            mem_q[wr_ptr_q].addr <= in_addr;
            mem_q[wr_ptr_q].data <= in_data;
        end
    end

    assign w_head  = mem_q[rd_ptr_q];
    assign wr_addr = wr_en ? w_head.addr : '0;
    assign wr_data = wr_en ? w_head.data : '0;
    assign count   = count_q;

`ifdef WB_BUFFER_FWD_EN
    wb_fwd_match #(
        .DEPTH (DEPTH)
    ) u_fwd1 (
        .entries_i (mem_q),
        .rd_ptr_i  (rd_ptr_q),
        .count_i   (count_q),
        .addr_i    (fwd_addr1),
        .hit_o     (fwd_hit1),
        .data_o    (fwd_data1)
    );

    wb_fwd_match #(
        .DEPTH (DEPTH)
    ) u_fwd2 (
        .entries_i (mem_q),
        .rd_ptr_i  (rd_ptr_q),
        .count_i   (count_q),
        .addr_i    (fwd_addr2),
        .hit_o     (fwd_hit2),
        .data_o    (fwd_data2)
    );
`else
    logic w_unused_fwd;

    assign w_unused_fwd = ^{fwd_addr1, fwd_addr2};
    assign fwd_hit1     = 1'b0;
    assign fwd_hit2     = 1'b0;
    assign fwd_data1    = '0;
    assign fwd_data2    = '0;
`endif

endmodule : wb_buffer

`default_nettype wire
